// File: rtl/rename_map_table.sv
// Speculative register alias table for a 4-wide rename stage, with a retirement map restored on flush.
// Optional feature: define RMT_ZERO_REG_EN to hardwire areg 0 to PR 0.
module rename_map_table #(
    parameter int unsigned NUM_AREG = 16,
    parameter int unsigned PR_W     = 6,
    localparam int unsigned AREG_W  = $clog2(NUM_AREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic [3:0]        i_ren_vld,
    input  logic [3:0]        i_dst_vld,
    input  logic [AREG_W-1:0] i_dst_areg0,
    input  logic [AREG_W-1:0] i_dst_areg1,
    input  logic [AREG_W-1:0] i_dst_areg2,
    input  logic [AREG_W-1:0] i_dst_areg3,
    input  logic [AREG_W-1:0] i_src1_areg0,
    input  logic [AREG_W-1:0] i_src1_areg1,
    input  logic [AREG_W-1:0] i_src1_areg2,
    input  logic [AREG_W-1:0] i_src1_areg3,
    input  logic [AREG_W-1:0] i_src2_areg0,
    input  logic [AREG_W-1:0] i_src2_areg1,
    input  logic [AREG_W-1:0] i_src2_areg2,
    input  logic [AREG_W-1:0] i_src2_areg3,
    input  logic [PR_W-1:0]   i_new_pr0,
    input  logic [PR_W-1:0]   i_new_pr1,
    input  logic [PR_W-1:0]   i_new_pr2,
    input  logic [PR_W-1:0]   i_new_pr3,
    input  logic [3:0]        i_cmt_en,
    input  logic [AREG_W-1:0] i_cmt_areg0,
    input  logic [AREG_W-1:0] i_cmt_areg1,
    input  logic [AREG_W-1:0] i_cmt_areg2,
    input  logic [AREG_W-1:0] i_cmt_areg3,
    input  logic [PR_W-1:0]   i_cmt_pr0,
    input  logic [PR_W-1:0]   i_cmt_pr1,
    input  logic [PR_W-1:0]   i_cmt_pr2,
    input  logic [PR_W-1:0]   i_cmt_pr3,
    output logic [3:0]        o_out_vld,
    output logic [PR_W-1:0]   o_src1_pr0,
    output logic [PR_W-1:0]   o_src1_pr1,
    output logic [PR_W-1:0]   o_src1_pr2,
    output logic [PR_W-1:0]   o_src1_pr3,
    output logic [PR_W-1:0]   o_src2_pr0,
    output logic [PR_W-1:0]   o_src2_pr1,
    output logic [PR_W-1:0]   o_src2_pr2,
    output logic [PR_W-1:0]   o_src2_pr3,
    output logic [PR_W-1:0]   o_dst_pr0,
    output logic [PR_W-1:0]   o_dst_pr1,
    output logic [PR_W-1:0]   o_dst_pr2,
    output logic [PR_W-1:0]   o_dst_pr3,
    output logic [PR_W-1:0]   o_old_pr0,
    output logic [PR_W-1:0]   o_old_pr1,
    output logic [PR_W-1:0]   o_old_pr2,
    output logic [PR_W-1:0]   o_old_pr3
);

    localparam int unsigned NSLOT = 4;

    logic [AREG_W-1:0] w_dst_areg  [NSLOT];
    logic [AREG_W-1:0] w_src1_areg [NSLOT];
    logic [AREG_W-1:0] w_src2_areg [NSLOT];
    logic [AREG_W-1:0] w_cmt_areg  [NSLOT];
    logic [PR_W-1:0]   w_new_pr    [NSLOT];
    logic [PR_W-1:0]   w_cmt_pr    [NSLOT];

    assign w_dst_areg  = '{i_dst_areg0, i_dst_areg1, i_dst_areg2, i_dst_areg3};
    assign w_src1_areg = '{i_src1_areg0, i_src1_areg1, i_src1_areg2, i_src1_areg3};
    assign w_src2_areg = '{i_src2_areg0, i_src2_areg1, i_src2_areg2, i_src2_areg3};
    assign w_cmt_areg  = '{i_cmt_areg0, i_cmt_areg1, i_cmt_areg2, i_cmt_areg3};
    assign w_new_pr    = '{i_new_pr0, i_new_pr1, i_new_pr2, i_new_pr3};
    assign w_cmt_pr    = '{i_cmt_pr0, i_cmt_pr1, i_cmt_pr2, i_cmt_pr3};

    logic [PR_W-1:0] r_spec_map   [NUM_AREG];
    logic [PR_W-1:0] r_retire_map [NUM_AREG];
    logic [PR_W-1:0] w_spec_nxt   [NUM_AREG];
    logic [PR_W-1:0] w_retire_nxt [NUM_AREG];

    logic [3:0]      r_out_vld;
    logic [PR_W-1:0] r_src1_pr [NSLOT];
    logic [PR_W-1:0] r_src2_pr [NSLOT];
    logic [PR_W-1:0] r_dst_pr  [NSLOT];
    logic [PR_W-1:0] r_old_pr  [NSLOT];

    logic [PR_W-1:0] w_src1_pr [NSLOT];
    logic [PR_W-1:0] w_src2_pr [NSLOT];
    logic [PR_W-1:0] w_dst_pr  [NSLOT];
    logic [PR_W-1:0] w_old_pr  [NSLOT];

    logic [NSLOT-1:0] w_alloc;
    logic [NSLOT-1:0] w_wr;
    logic [NSLOT-1:0] w_cmt_wr;

    // Slots that actually write a map entry (areg 0 excluded when hardwired)
    always_comb begin
        w_alloc  = i_ren_vld & i_dst_vld;
        w_wr     = w_alloc;
        w_cmt_wr = i_cmt_en;
`ifdef RMT_ZERO_REG_EN
        for (int k = 0; k < NSLOT; k++) begin
            if (w_dst_areg[k] == '0) w_wr[k] = 1'b0;
            if (w_cmt_areg[k] == '0) w_cmt_wr[k] = 1'b0;
        end
`endif
    end

    // Source / displaced-mapping lookup with forwarding from older slots in the group
    always_comb begin
        for (int k = 0; k < NSLOT; k++) begin
            w_src1_pr[k] = r_spec_map[w_src1_areg[k]];
            w_src2_pr[k] = r_spec_map[w_src2_areg[k]];
            w_old_pr[k]  = r_spec_map[w_dst_areg[k]];
            for (int j = 0; j < k; j++) begin
                if (w_wr[j]) begin
                    if (w_dst_areg[j] == w_src1_areg[k]) w_src1_pr[k] = w_new_pr[j];
                    if (w_dst_areg[j] == w_src2_areg[k]) w_src2_pr[k] = w_new_pr[j];
                    if (w_dst_areg[j] == w_dst_areg[k])  w_old_pr[k]  = w_new_pr[j];
                end
            end
`ifdef RMT_ZERO_REG_EN
            if (w_src1_areg[k] == '0) w_src1_pr[k] = '0;
            if (w_src2_areg[k] == '0) w_src2_pr[k] = '0;
            if (w_dst_areg[k] == '0)  w_old_pr[k]  = w_new_pr[k];
`endif
            w_dst_pr[k] = w_alloc[k] ? w_new_pr[k] : '0;
            if (!w_alloc[k]) w_old_pr[k] = '0;
        end
    end

    // Next-state maps: youngest matching slot wins
    always_comb begin
        for (int a = 0; a < NUM_AREG; a++) begin
            w_spec_nxt[a]   = r_spec_map[a];
            w_retire_nxt[a] = r_retire_map[a];
            for (int j = 0; j < NSLOT; j++) begin
                if (w_wr[j] && (w_dst_areg[j] == AREG_W'(a)))     w_spec_nxt[a]   = w_new_pr[j];
                if (w_cmt_wr[j] && (w_cmt_areg[j] == AREG_W'(a))) w_retire_nxt[a] = w_cmt_pr[j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < NUM_AREG; a++) begin
                r_spec_map[a]   <= PR_W'(a);
                r_retire_map[a] <= PR_W'(a);
            end
            r_out_vld <= '0;
            for (int k = 0; k < NSLOT; k++) begin
                r_src1_pr[k] <= '0;
                r_src2_pr[k] <= '0;
                r_dst_pr[k]  <= '0;
                r_old_pr[k]  <= '0;
            end
        end else if (!i_stall) begin
            r_retire_map <= w_retire_nxt;
            if (i_flush) begin
                r_spec_map <= w_retire_nxt;
                r_out_vld  <= '0;
                for (int k = 0; k < NSLOT; k++) begin
                    r_src1_pr[k] <= '0;
                    r_src2_pr[k] <= '0;
                    r_dst_pr[k]  <= '0;
                    r_old_pr[k]  <= '0;
                end
            end else begin
                r_spec_map <= w_spec_nxt;
                r_out_vld  <= i_ren_vld;
                r_src1_pr  <= w_src1_pr;
                r_src2_pr  <= w_src2_pr;
                r_dst_pr   <= w_dst_pr;
                r_old_pr   <= w_old_pr;
            end
        end
    end

    assign o_out_vld  = r_out_vld;
    assign o_src1_pr0 = r_src1_pr[0];
    assign o_src1_pr1 = r_src1_pr[1];
    assign o_src1_pr2 = r_src1_pr[2];
    assign o_src1_pr3 = r_src1_pr[3];
    assign o_src2_pr0 = r_src2_pr[0];
    assign o_src2_pr1 = r_src2_pr[1];
    assign o_src2_pr2 = r_src2_pr[2];
    assign o_src2_pr3 = r_src2_pr[3];
    assign o_dst_pr0  = r_dst_pr[0];
    assign o_dst_pr1  = r_dst_pr[1];
    assign o_dst_pr2  = r_dst_pr[2];
    assign o_dst_pr3  = r_dst_pr[3];
    assign o_old_pr0  = r_old_pr[0];
    assign o_old_pr1  = r_old_pr[1];
    assign o_old_pr2  = r_old_pr[2];
    assign o_old_pr3  = r_old_pr[3];

endmodule

// File: tb/tb_rename_map_table.sv
// Bench for rename_map_table: in-order group model plus directed literal checks.
module tb_rename_map_table;

    logic       clk;
    logic       rst_n;
    logic       stall, flush;
    logic [3:0] ren_vld, dst_vld, cmt_en;
    logic [3:0] dst_areg [4];
    logic [3:0] src1_areg [4];
    logic [3:0] src2_areg [4];
    logic [3:0] cmt_areg [4];
    logic [5:0] new_pr [4];
    logic [5:0] cmt_pr [4];
    logic [3:0] o_vld;
    logic [5:0] o_s1 [4];
    logic [5:0] o_s2 [4];
    logic [5:0] o_dst [4];
    logic [5:0] o_old [4];

    rename_map_table dut (
        .clk(clk), .rst_n(rst_n), .i_stall(stall), .i_flush(flush),
        .i_ren_vld(ren_vld), .i_dst_vld(dst_vld),
        .i_dst_areg0(dst_areg[0]), .i_dst_areg1(dst_areg[1]),
        .i_dst_areg2(dst_areg[2]), .i_dst_areg3(dst_areg[3]),
        .i_src1_areg0(src1_areg[0]), .i_src1_areg1(src1_areg[1]),
        .i_src1_areg2(src1_areg[2]), .i_src1_areg3(src1_areg[3]),
        .i_src2_areg0(src2_areg[0]), .i_src2_areg1(src2_areg[1]),
        .i_src2_areg2(src2_areg[2]), .i_src2_areg3(src2_areg[3]),
        .i_new_pr0(new_pr[0]), .i_new_pr1(new_pr[1]),
        .i_new_pr2(new_pr[2]), .i_new_pr3(new_pr[3]),
        .i_cmt_en(cmt_en),
        .i_cmt_areg0(cmt_areg[0]), .i_cmt_areg1(cmt_areg[1]),
        .i_cmt_areg2(cmt_areg[2]), .i_cmt_areg3(cmt_areg[3]),
        .i_cmt_pr0(cmt_pr[0]), .i_cmt_pr1(cmt_pr[1]),
        .i_cmt_pr2(cmt_pr[2]), .i_cmt_pr3(cmt_pr[3]),
        .o_out_vld(o_vld),
        .o_src1_pr0(o_s1[0]), .o_src1_pr1(o_s1[1]), .o_src1_pr2(o_s1[2]), .o_src1_pr3(o_s1[3]),
        .o_src2_pr0(o_s2[0]), .o_src2_pr1(o_s2[1]), .o_src2_pr2(o_s2[2]), .o_src2_pr3(o_s2[3]),
        .o_dst_pr0(o_dst[0]), .o_dst_pr1(o_dst[1]), .o_dst_pr2(o_dst[2]), .o_dst_pr3(o_dst[3]),
        .o_old_pr0(o_old[0]), .o_old_pr1(o_old[1]), .o_old_pr2(o_old[2]), .o_old_pr3(o_old[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

`ifdef RMT_ZERO_REG_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    // Architectural view: maps as plain arrays, expected outputs after the last edge
    int m_spec [16];
    int m_ret  [16];
    bit [3:0] e_vld;
    int e_s1 [4];
    int e_s2 [4];
    int e_dst [4];
    int e_old [4];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 16; a++) begin
            m_spec[a] = a;
            m_ret[a]  = a;
        end
        e_vld = '0;
        for (int k = 0; k < 4; k++) begin
            e_s1[k] = 0; e_s2[k] = 0; e_dst[k] = 0; e_old[k] = 0;
        end
    endtask

    task automatic clr_in();
        stall = 0; flush = 0; ren_vld = '0; dst_vld = '0; cmt_en = '0;
        for (int k = 0; k < 4; k++) begin
            dst_areg[k] = '0; src1_areg[k] = '0; src2_areg[k] = '0;
            cmt_areg[k] = '0; new_pr[k] = '0; cmt_pr[k] = '0;
        end
    endtask

    task automatic set_slot(input int k, input bit has_dst, input int d, input int pr,
                            input int s1, input int s2);
        ren_vld[k]   = 1'b1;
        dst_vld[k]   = has_dst;
        dst_areg[k]  = 4'(d);
        new_pr[k]    = 6'(pr);
        src1_areg[k] = 4'(s1);
        src2_areg[k] = 4'(s2);
    endtask

    // Instructions processed in program order against a working copy of the map
    task automatic cycle();
        int g [16];
        int r [16];
        bit [3:0] n_vld;
        int n_s1 [4];
        int n_s2 [4];
        int n_dst [4];
        int n_old [4];
        g = m_spec;
        r = m_ret;
        for (int k = 0; k < 4; k++) begin
            int s1, s2, d;
            s1 = int'(src1_areg[k]); s2 = int'(src2_areg[k]); d = int'(dst_areg[k]);
            n_vld[k] = ren_vld[k];
            n_s1[k]  = (ZERO && s1 == 0) ? 0 : g[s1];
            n_s2[k]  = (ZERO && s2 == 0) ? 0 : g[s2];
            if (ren_vld[k] && dst_vld[k]) begin
                n_dst[k] = int'(new_pr[k]);
                if (ZERO && d == 0) n_old[k] = int'(new_pr[k]);
                else begin
                    n_old[k] = g[d];
                    g[d] = int'(new_pr[k]);
                end
            end else begin
                n_dst[k] = 0;
                n_old[k] = 0;
            end
        end
        for (int j = 0; j < 4; j++)
            if (cmt_en[j] && !(ZERO && cmt_areg[j] == 0)) r[int'(cmt_areg[j])] = int'(cmt_pr[j]);
        @(posedge clk);
        if (!stall) begin
            m_ret = r;
            if (flush) begin
                m_spec = r;
                e_vld  = '0;
            end else begin
                m_spec = g;
                e_vld  = n_vld;
                e_s1 = n_s1; e_s2 = n_s2; e_dst = n_dst; e_old = n_old;
            end
        end
        #1;
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_vld", int'(o_vld), int'(e_vld));
            for (int k = 0; k < 4; k++) begin
                if (e_vld[k]) begin
                    chk($sformatf("src1_pr%0d", k), int'(o_s1[k]), e_s1[k]);
                    chk($sformatf("src2_pr%0d", k), int'(o_s2[k]), e_s2[k]);
                    chk($sformatf("dst_pr%0d", k),  int'(o_dst[k]), e_dst[k]);
                    chk($sformatf("old_pr%0d", k),  int'(o_old[k]), e_old[k]);
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vld"}, int'(o_vld), 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_s1_%0d", tag, k), int'(o_s1[k]), 0);
            chk($sformatf("%s_dst_%0d", tag, k), int'(o_dst[k]), 0);
            chk($sformatf("%s_old_%0d", tag, k), int'(o_old[k]), 0);
        end
    endtask

    initial begin
        clr_in();
        model_reset();
        rst_n = 1'b0;
        #3;
        chk_all_zero("reset");
        @(posedge clk); #2;
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Basic rename then lookup of the new mapping
        clr_in(); set_slot(0, 1, 3, 16, 3, 0); cycle();
        chk("t1_dst_pr0", int'(o_dst[0]), 16);
        chk("t1_old_pr0", int'(o_old[0]), 3);
        chk("t1_src1_pr0", int'(o_s1[0]), 3);
        clr_in(); set_slot(0, 0, 0, 0, 3, 4); cycle();
        chk("t1b_src1_pr0", int'(o_s1[0]), 16);
        chk("t1b_dst_pr0", int'(o_dst[0]), 0);

        // Intra-group forwarding
        clr_in();
        set_slot(0, 1, 5, 20, 1, 2);
        set_slot(1, 1, 5, 21, 5, 6);
        set_slot(3, 0, 0, 0, 7, 5);
        cycle();
        chk("t2_src1_pr1", int'(o_s1[1]), 20);
        chk("t2_old_pr1", int'(o_old[1]), 20);
        chk("t2_src2_pr3", int'(o_s2[3]), 21);
        clr_in(); set_slot(0, 0, 0, 0, 5, 3); cycle();
        chk("t2b_src1_pr0", int'(o_s1[0]), 21);

        // Stall holds outputs and maps
        clr_in(); set_slot(0, 1, 9, 33, 9, 5); stall = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_src1_pr0", int'(o_s1[0]), 21);
            chk("stall_vld", int'(o_vld), 1);
        end
        stall = 0; cycle();
        chk("unstall_dst_pr0", int'(o_dst[0]), 33);
        chk("unstall_old_pr0", int'(o_old[0]), 9);
        chk("unstall_src1_pr0", int'(o_s1[0]), 9);
        clr_in(); set_slot(0, 0, 0, 0, 9, 3); cycle();
        chk("unstall_b_src1", int'(o_s1[0]), 33);

        // Flush without commit restores reset mapping
        clr_in(); set_slot(0, 1, 7, 30, 1, 1); cycle();
        clr_in(); set_slot(0, 1, 7, 31, 7, 7); flush = 1; cycle();
        chk("flush_vld", int'(o_vld), 0);
        clr_in(); set_slot(0, 0, 0, 0, 7, 5); set_slot(1, 0, 0, 0, 3, 9); cycle();
        chk("flush_src7", int'(o_s1[0]), 7);
        chk("flush_src5", int'(o_s2[0]), 5);
        chk("flush_src3", int'(o_s1[1]), 3);

        // Flush together with commit; youngest commit slot wins
        clr_in(); set_slot(0, 1, 7, 30, 2, 2); cycle();
        clr_in(); flush = 1;
        cmt_en = 4'b0011;
        cmt_areg[0] = 4'd7; cmt_pr[0] = 6'd12;
        cmt_areg[1] = 4'd7; cmt_pr[1] = 6'd30;
        cycle();
        clr_in(); set_slot(0, 0, 0, 0, 7, 7); cycle();
        chk("cmtflush_src7", int'(o_s1[0]), 30);

        // Same areg written by all four slots
        clr_in();
        set_slot(0, 1, 2, 40, 2, 7);
        set_slot(1, 1, 2, 41, 2, 3);
        set_slot(2, 1, 2, 42, 2, 1);
        set_slot(3, 1, 2, 43, 2, 2);
        cycle();
        chk("chain_old0", int'(o_old[0]), 2);
        chk("chain_src1_3", int'(o_s1[3]), 42);
        chk("chain_old3", int'(o_old[3]), 42);
        clr_in(); set_slot(2, 0, 0, 0, 2, 7); cycle();
        chk("chain_after", int'(o_s1[2]), 43);

        // Asynchronous reset mid-operation
        clr_in();
        set_slot(0, 1, 4, 50, 4, 4); set_slot(1, 1, 6, 51, 4, 6);
        cycle();
        chk_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        clr_in();
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        chk_en = 1'b1;
        for (int c = 0; c < 2; c++) begin
            clr_in();
            for (int k = 0; k < 4; k++) set_slot(k, 0, 0, 0, c * 8 + k, c * 8 + k + 4);
            cycle();
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("post_rst_s1_%0d", c * 8 + k), int'(o_s1[k]), c * 8 + k);
                chk($sformatf("post_rst_s2_%0d", c * 8 + k + 4), int'(o_s2[k]), c * 8 + k + 4);
            end
        end

        // Areg 0 handling
        clr_in(); set_slot(0, 1, 0, 40, 1, 1); cycle();
        clr_in(); set_slot(0, 0, 0, 0, 0, 1); cycle();
`ifdef RMT_ZERO_REG_EN
        chk("zero_src_pr", int'(o_s1[0]), 0);
`else
        chk("zero_src_pr", int'(o_s1[0]), 40);
`endif
        clr_in(); set_slot(0, 1, 0, 44, 0, 0); cycle();
`ifdef RMT_ZERO_REG_EN
        chk("zero_old_pr", int'(o_old[0]), 44);
`else
        chk("zero_old_pr", int'(o_old[0]), 40);
`endif

        clr_in(); cycle(); cycle();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rename_map_table.md
# rename_map_table

Speculative register alias table for the 4-wide rename stage, directly downstream of the free list. It consumes up to four new physical register numbers per cycle from the free list. It maps source architectural registers to physical registers, including intra-group dependency forwarding, and records the displaced mapping for each destination so it can be freed later. A retirement map is updated by commit and is copied into the speculative map on flush.

## Interface
Parameters:
- NUM_AREG, 16: architectural registers; index width 4.
- PR_W, 6: physical register number width (64 PRs).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- stall  input  1  freeze all state and outputs.
- flush  input  1  restore the speculative map from the retirement map.
- ren_vld  input  4  slot k carries a valid instruction.
- dst_vld  input  4  slot k writes a destination; same vector drives the free list's pr_need_inst_in.
- dst_areg0..3  input  4 each  destination architectural register.
- src1_areg0..3, src2_areg0..3  input  4 each  source architectural registers.
- new_pr0..3  input  PR_W each  free list pr_num_out0..3, aligned to slot.
- cmt_en  input  4  commit slot k valid.
- cmt_areg0..3  input  4 each; cmt_pr0..3  input  PR_W each  committed mapping.
- out_vld  output  4  registered ren_vld.
- src1_pr0..3, src2_pr0..3  output  PR_W each  renamed sources.
- dst_pr0..3  output  PR_W each  allocated PR (registered new_pr).
- old_pr0..3  output  PR_W each  mapping displaced by slot k, for freeing at commit.

## Operation
- Reset: spec_map[i] = retire_map[i] = i (i = 0..15), matching free list entries 0..15 as in use. All outputs are 0.
- Lookup for slot k, combinational from spec_map:
  - src*_pr: if any slot j<k has ren_vld&dst_vld and dst_areg_j equal to the source, use new_pr of the highest such j; otherwise use spec_map.
  - old_pr_k: same rule applied to dst_areg_k.
- Update, when not stall and not flush: for each areg, spec_map takes new_pr of the highest slot with ren_vld&dst_vld and a matching dst_areg. Untouched entries hold.
- A slot with dst_vld=0 leaves the map unchanged; its dst_pr and old_pr are registered as 0.
- Commit, when not stall: for each areg, retire_map takes cmt_pr of the highest enabled slot with a matching cmt_areg. Commit proceeds during flush.
- Flush, when not stall: spec_map takes the retire_map value after this cycle's commits are applied. The rename group is discarded and out_vld is 0 next cycle.
- Priority: stall > flush > rename.

## Timing
- Outputs are registered, with 1-cycle latency from ren_vld to out_vld and the associated fields.
- A rename in cycle N is visible to lookups in cycle N+1 with no bubble.
- During stall, all registers hold, including the outputs. Upstream must hold its inputs.
- Flush in cycle N means renames in cycle N+1 see the restored map.
- Reset asserted mid-operation returns both maps and all outputs to their reset values immediately (asynchronous reset).

## Configuration
- RMT_ZERO_REG_EN defined:
  - areg 0 is hardwired to PR 0.
  - Sources naming areg 0 return 0 and are never forwarded.
  - A dst to areg 0 never updates either map; old_pr_k is set to new_pr_k so that its later free recycles the allocation.
  - Commits to areg 0 are ignored.
- Undefined: areg 0 is an ordinary renamed register.

## Test plan
- Reset, then one rename with slot0 dst=3, new_pr0=16, src1=3 → next cycle: dst_pr0=16, old_pr0=3, src1_pr0=3. A following rename with src1=3 → src1_pr0=16.
- One group: slot0 dst=5/pr20, slot1 src1=5 dst=5/pr21, slot3 src2=5 → src1_pr1=20, old_pr1=20, src2_pr3=21, and spec_map[5]=21.
- Stall held for 3 cycles with new inputs → outputs and maps unchanged; rename resumes with no loss.
- Rename areg 7→30 and do not commit, then commit areg 7→30 in the same cycle as flush → the next rename of src 7 reads 30. With no commit, flush → src 7 reads 7.
- Apply rst_n low mid-group → all outputs 0 immediately; after release, areg i reads PR i.
- With RMT_ZERO_REG_EN: dst=0, new_pr=40, then src=0 → src_pr=0 and old_pr=40. Without the macro: src_pr=40 and old_pr=0.
